// File: rtl/core_run_ctrl.sv
// Run/halt/step sequencer for the single-cycle RISC-V core: gates the core clock-enable,
// issues restarts, streams words into instruction memory and halts on a PC breakpoint.
module core_run_ctrl #(
    parameter int PROG_AW = 8,
    parameter int CNT_W   = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [2:0]         cmd_op_i,
    input  logic [31:0]        cmd_arg_i,
    input  logic [31:0]        core_pc_i,
    input  logic [31:0]        core_last_pc_i,
    output logic               core_en_o,
    output logic               core_restart_o,
    output logic               prog_we_o,
    output logic [PROG_AW-1:0] prog_addr_o,
    output logic [31:0]        prog_data_o,
    output logic               halted_o,
    output logic               bp_hit_o,
    output logic               at_end_o,
    output logic               cmd_err_o,
    output logic [CNT_W-1:0]   retired_o
);

    typedef enum logic [1:0] {
        ST_HALTED  = 2'd0,
        ST_RUN     = 2'd1,
        ST_STEP    = 2'd2,
        ST_RESTART = 2'd3
    } state_e;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_RUN     = 3'd1;
    localparam logic [2:0] OP_HALT    = 3'd2;
    localparam logic [2:0] OP_STEP    = 3'd3;
    localparam logic [2:0] OP_SET_BP  = 3'd4;
    localparam logic [2:0] OP_CLR_BP  = 3'd5;
    localparam logic [2:0] OP_LOAD    = 3'd6;
    localparam logic [2:0] OP_RESTART = 3'd7;

    state_e               state_q, state_d;
    logic                 restart_q, restart_d;
    logic                 prog_we_q, prog_we_d;
    logic [PROG_AW-1:0]   prog_addr_q, prog_addr_d;
    logic [31:0]          prog_data_q, prog_data_d;
    logic [PROG_AW-1:0]   load_ptr_q, load_ptr_d;
    logic                 bp_en_q, bp_en_d;
    logic [31:0]          bp_addr_q, bp_addr_d;
    logic                 bp_hit_q, bp_hit_d;
    logic                 cmd_err_q, cmd_err_d;
    logic [CNT_W-1:0]     retired_q, retired_d;
    logic [31:0]          step_left_q, step_left_d;
    logic                 skip_q, skip_d;

    logic                 accept;
    logic                 bp_at_pc;
    logic                 bp_match;
    logic                 active;
    logic                 halt_cmd;
    logic                 bad_in_active;

    assign accept    = cmd_valid_i & cmd_ready_o;
    assign bp_at_pc  = (core_pc_i == bp_addr_q);
    // skip lets a resume execute the instruction sitting on the breakpoint once
    assign bp_match  = bp_en_q & bp_at_pc & ~skip_q;
    assign active    = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign halt_cmd  = accept && (cmd_op_i == OP_HALT);
    assign bad_in_active = (cmd_op_i == OP_RUN) || (cmd_op_i == OP_STEP) ||
                           (cmd_op_i == OP_LOAD) || (cmd_op_i == OP_RESTART);

    assign cmd_ready_o    = (state_q != ST_RESTART);
    assign core_en_o      = active & ~bp_match;
    assign core_restart_o = restart_q;
    assign prog_we_o      = prog_we_q;
    assign prog_addr_o    = prog_addr_q;
    assign prog_data_o    = prog_data_q;
    assign halted_o       = (state_q == ST_HALTED);
    assign bp_hit_o       = bp_hit_q;
    assign at_end_o       = halted_o & (core_pc_i == core_last_pc_i);
    assign cmd_err_o      = cmd_err_q;
    assign retired_o      = retired_q;

    always_comb begin
        state_d     = state_q;
        restart_d   = 1'b0;
        prog_we_d   = 1'b0;
        prog_addr_d = prog_addr_q;
        prog_data_d = prog_data_q;
        load_ptr_d  = load_ptr_q;
        bp_en_d     = bp_en_q;
        bp_addr_d   = bp_addr_q;
        bp_hit_d    = bp_hit_q;
        cmd_err_d   = 1'b0;
        retired_d   = retired_q;
        step_left_d = step_left_q;
        skip_d      = skip_q;

        if (core_en_o) begin
            skip_d = 1'b0;
            if (retired_q != {CNT_W{1'b1}}) begin
                retired_d = retired_q + CNT_W'(1);
            end
        end

        // Breakpoint edits are legal whenever a command is accepted
        if (accept && (cmd_op_i == OP_SET_BP)) begin
            bp_addr_d = cmd_arg_i;
            bp_en_d   = 1'b1;
        end
        if (accept && (cmd_op_i == OP_CLR_BP)) begin
            bp_en_d = 1'b0;
        end

        case (state_q)
            ST_HALTED: begin
                if (accept) begin
                    case (cmd_op_i)
                        OP_RUN: begin
                            state_d  = ST_RUN;
                            skip_d   = bp_en_q & bp_at_pc;
                            bp_hit_d = 1'b0;
                        end
                        OP_STEP: begin
                            state_d     = ST_STEP;
                            step_left_d = (cmd_arg_i == 32'd0) ? 32'd1 : cmd_arg_i;
                            skip_d      = bp_en_q & bp_at_pc;
                            bp_hit_d    = 1'b0;
                        end
                        OP_LOAD: begin
                            prog_we_d   = 1'b1;
                            prog_addr_d = load_ptr_q;
                            prog_data_d = cmd_arg_i;
                            load_ptr_d  = load_ptr_q + PROG_AW'(1);
                        end
                        OP_RESTART: begin
                            state_d   = ST_RESTART;
                            restart_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            ST_RUN, ST_STEP: begin
                if (accept && bad_in_active) begin
                    cmd_err_d = 1'b1;
                end
                if (bp_match) begin
                    // The breakpointed instruction is not executed; a racing HALT is absorbed here
                    state_d     = ST_HALTED;
                    bp_hit_d    = 1'b1;
                    step_left_d = 32'd0;
                end else begin
                    if (state_q == ST_STEP) begin
                        step_left_d = step_left_q - 32'd1;
                        if (step_left_q == 32'd1) begin
                            state_d = ST_HALTED;
                        end
                    end
                    if (halt_cmd) begin
                        state_d     = ST_HALTED;
                        step_left_d = 32'd0;
                    end
                end
            end

            ST_RESTART: begin
                state_d    = ST_HALTED;
                load_ptr_d = '0;
                retired_d  = '0;
                bp_hit_d   = 1'b0;
            end

            default: state_d = ST_HALTED;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_HALTED;
            restart_q   <= 1'b0;
            prog_we_q   <= 1'b0;
            prog_addr_q <= '0;
            prog_data_q <= '0;
            load_ptr_q  <= '0;
            bp_en_q     <= 1'b0;
            bp_addr_q   <= '0;
            bp_hit_q    <= 1'b0;
            cmd_err_q   <= 1'b0;
            retired_q   <= '0;
            step_left_q <= '0;
            skip_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            restart_q   <= restart_d;
            prog_we_q   <= prog_we_d;
            prog_addr_q <= prog_addr_d;
            prog_data_q <= prog_data_d;
            load_ptr_q  <= load_ptr_d;
            bp_en_q     <= bp_en_d;
            bp_addr_q   <= bp_addr_d;
            bp_hit_q    <= bp_hit_d;
            cmd_err_q   <= cmd_err_d;
            retired_q   <= retired_d;
            step_left_q <= step_left_d;
            skip_q      <= skip_d;
        end
    end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: a tiny core pc model, a table of single-cycle command vectors,
// a load scoreboard, and hand sequences for breakpoint, step, reset and wrap corners.
module tb_core_run_ctrl;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_RUN     = 3'd1;
    localparam logic [2:0] OP_HALT    = 3'd2;
    localparam logic [2:0] OP_STEP    = 3'd3;
    localparam logic [2:0] OP_SET_BP  = 3'd4;
    localparam logic [2:0] OP_CLR_BP  = 3'd5;
    localparam logic [2:0] OP_LOAD    = 3'd6;
    localparam logic [2:0] OP_RESTART = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_arg;
    logic [31:0] core_pc;
    logic [31:0] core_last_pc;
    logic        core_en;
    logic        core_restart;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [31:0] prog_data;
    logic        halted;
    logic        bp_hit;
    logic        at_end;
    logic        cmd_err;
    logic [31:0] retired;

    core_run_ctrl #(.PROG_AW(8), .CNT_W(32)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_op_i       (cmd_op),
        .cmd_arg_i      (cmd_arg),
        .core_pc_i      (core_pc),
        .core_last_pc_i (core_last_pc),
        .core_en_o      (core_en),
        .core_restart_o (core_restart),
        .prog_we_o      (prog_we),
        .prog_addr_o    (prog_addr),
        .prog_data_o    (prog_data),
        .halted_o       (halted),
        .bp_hit_o       (bp_hit),
        .at_end_o       (at_end),
        .cmd_err_o      (cmd_err),
        .retired_o      (retired)
    );

    always #5 clk = ~clk;

    // Single-cycle core: advances while enabled, self-stalls at the last pc
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               core_pc <= 32'hFFFF_FFFF;
        else if (core_restart)                    core_pc <= 32'hFFFF_FFFF;
        else if (core_en && core_pc != core_last_pc) core_pc <= core_pc + 32'd1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          cyc;
    } sb_t;

    typedef struct {
        logic        valid;
        logic [2:0]  op;
        logic [31:0] arg;
        logic        halted;
        logic        en;
        logic        err;
        logic        restart;
        logic        ready;
    } vec_t;

    sb_t        sb_q[$];
    sb_t        mon_e;
    vec_t       vt[14];
    int         total = 0;
    int         bad = 0;
    int         en_cnt = 0;
    int         en_base;
    logic [7:0] exp_ptr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] arg);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        $display("cmd op=%0d arg=%08h", op, arg);
    endtask

    task automatic do_restart();
        send(OP_RESTART, 32'd0);
        @(posedge clk);
        #1 exp_ptr = 8'd0;
    endtask

    task automatic load_burst(input int n, input logic [31:0] first_word, input logic use_rand);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            w = use_rand ? $urandom : first_word + 32'h80 * i;
            cmd_valid = 1'b1;
            cmd_op    = OP_LOAD;
            cmd_arg   = w;
            sb_q.push_back('{exp_ptr, w, cyc + 1});
            exp_ptr = exp_ptr + 8'd1;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_halted(input int bound);
        for (int i = 0; i < bound && !halted; i++) @(negedge clk);
        chk("wait_halted", halted, 1);
    endtask

    initial begin
        rst_n        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_op       = OP_NOP;
        cmd_arg      = 32'd0;
        core_last_pc = 32'd100;
        exp_ptr      = 8'd0;

        vt[0]  = '{1'b1, OP_NOP,     32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[1]  = '{1'b1, OP_SET_BP,  32'h50, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[2]  = '{1'b1, OP_RUN,     32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[3]  = '{1'b1, OP_LOAD,    32'h5,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[4]  = '{1'b1, OP_STEP,    32'h2,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[5]  = '{1'b1, OP_RESTART, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[6]  = '{1'b1, OP_CLR_BP,  32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[7]  = '{1'b1, OP_HALT,    32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[8]  = '{1'b1, OP_HALT,    32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[9]  = '{1'b1, OP_STEP,    32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[10] = '{1'b1, OP_NOP,     32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[11] = '{1'b1, OP_RESTART, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[12] = '{1'b1, OP_NOP,     32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[13] = '{1'b0, OP_NOP,     32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        // Load scoreboard and enabled-cycle counter share the negedge sample point
        fork
            forever begin
                @(negedge clk);
                if (core_en) en_cnt++;
                if (rst_n && prog_we) begin
                    if (sb_q.size() == 0) begin
                        chk("prog_we_unexpected", prog_we, 0);
                    end else begin
                        mon_e = sb_q.pop_front();
                        $display("load addr=%02h data=%08h", prog_addr, prog_data);
                        chk("prog_addr", prog_addr, mon_e.addr);
                        chk("prog_data", prog_data, mon_e.data);
                        chk("prog_lag", cyc, mon_e.cyc);
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_halted", halted, 1);
        chk("rst_core_en", core_en, 0);
        chk("rst_restart", core_restart, 0);
        chk("rst_prog_we", prog_we, 0);
        chk("rst_retired", retired, 0);
        chk("rst_bp_hit", bp_hit, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        rst_n = 1'b1;

        // Back-to-back loads
        load_burst(4, 32'h13, 1'b0);
        chk("load4_drained", sb_q.size(), 0);

        // Command table, one accepted command per cycle
        do_restart();
        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            cmd_valid = vt[i].valid;
            cmd_op    = vt[i].op;
            cmd_arg   = vt[i].arg;
            @(posedge clk);
            #1 cmd_valid = 1'b0;
            @(negedge clk);
            $display("vec %0d op=%0d halted=%0b en=%0b err=%0b rs=%0b rdy=%0b",
                     i, vt[i].op, halted, core_en, cmd_err, core_restart, cmd_ready);
            chk($sformatf("vec%0d_halted", i), halted, vt[i].halted);
            chk($sformatf("vec%0d_core_en", i), core_en, vt[i].en);
            chk($sformatf("vec%0d_cmd_err", i), cmd_err, vt[i].err);
            chk($sformatf("vec%0d_restart", i), core_restart, vt[i].restart);
            chk($sformatf("vec%0d_ready", i), cmd_ready, vt[i].ready);
        end
        exp_ptr = 8'd0;

        // STEP 3 after restart
        do_restart();
        en_base = en_cnt;
        send(OP_STEP, 32'd3);
        wait_halted(20);
        @(negedge clk);
        chk("step3_en_cycles", en_cnt - en_base, 3);
        chk("step3_retired", retired, 3);
        chk("step3_bp_hit", bp_hit, 0);

        // Breakpoint at pc 2
        do_restart();
        send(OP_SET_BP, 32'd2);
        send(OP_RUN, 32'd0);
        wait_halted(20);
        chk("bp_pc", core_pc, 2);
        chk("bp_retired", retired, 3);
        chk("bp_hit", bp_hit, 1);
        send(OP_RUN, 32'd0);
        chk("resume_bp_hit_clr", bp_hit, 0);
        repeat (4) @(negedge clk);
        chk("resume_running", halted, 0);
        chk("resume_pc", core_pc, 5);
        send(OP_HALT, 32'd0);
        chk("resume_halt_en", core_en, 0);
        chk("resume_retired", retired, 8);
        chk("resume_pc_final", core_pc, 7);

        // Breakpoint survives RESTART and re-triggers when pc revisits it
        do_restart();
        send(OP_RUN, 32'd0);
        wait_halted(20);
        chk("bp_kept_pc", core_pc, 2);
        chk("bp_kept_hit", bp_hit, 1);

        // HALT accepted in the very cycle the breakpoint matches
        do_restart();
        send(OP_RUN, 32'd0);
        repeat (3) @(posedge clk);
        send(OP_HALT, 32'd0);
        chk("race_halted", halted, 1);
        chk("race_bp_hit", bp_hit, 1);
        chk("race_pc", core_pc, 2);
        chk("race_retired", retired, 3);

        // LOAD while running is rejected
        send(OP_CLR_BP, 32'd0);
        do_restart();
        send(OP_RUN, 32'd0);
        send(OP_LOAD, 32'hDEAD);
        chk("runload_err", cmd_err, 1);
        chk("runload_we", prog_we, 0);
        @(posedge clk);
        #1;
        chk("runload_err_pulse", cmd_err, 0);
        chk("runload_still_en", core_en, 1);
        send(OP_HALT, 32'd0);
        chk("halt_en", core_en, 0);
        chk("halt_halted", halted, 1);

        // Asynchronous reset mid-STEP
        send(OP_STEP, 32'd8);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_core_en", core_en, 0);
        chk("arst_halted", halted, 1);
        chk("arst_prog_addr", prog_addr, 0);
        chk("arst_prog_data", prog_data, 0);
        chk("arst_retired", retired, 0);
        chk("arst_bp_hit", bp_hit, 0);
        chk("arst_cmd_err", cmd_err, 0);
        chk("arst_restart", core_restart, 0);
        exp_ptr = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;

        // Run to last pc, HALT, then a wrapping load stream
        core_last_pc = 32'd6;
        send(OP_RUN, 32'd0);
        chk("end_not_yet", at_end, 0);
        for (int i = 0; i < 40 && core_pc != core_last_pc; i++) @(negedge clk);
        chk("reach_last_pc", core_pc, 6);
        repeat (2) @(negedge clk);
        send(OP_HALT, 32'd0);
        chk("at_end", at_end, 1);
        load_burst(257, 32'd0, 1'b1);
        chk("wrap_last_addr", prog_addr, 0);
        chk("wrap_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
